// File: rtl/wbc_lclk_pkg.sv
// -----------------------------------------------------------------------------
// wbc_lclk_pkg
// Shared constants and types for the KW11-L compatible line-clock peripheral.
//   - CSR bit positions (monitor, interrupt enable)
//   - Unibus address of the CSR (decoded outside this block)
//   - Default interrupt vector
//   - CSR state struct and the helper that packs it into a bus word
// -----------------------------------------------------------------------------
package wbc_lclk_pkg;

    localparam int          LCLK_MON_BIT        = 7;
    localparam int          LCLK_IE_BIT         = 6;
    localparam logic [15:0] LCLK_CSR_ADDR       = 16'o177546;
    localparam logic [15:0] LCLK_DEFAULT_VECTOR = 16'o000100;

    // Architecturally visible CSR bits; every other bit reads as zero.
    typedef struct packed {
        logic mon;
        logic ie;
    } lclk_csr_t;

    function automatic logic [15:0] lclk_csr_pack(input lclk_csr_t csr);
        logic [15:0] word;
        word               = '0;
        word[LCLK_MON_BIT] = csr.mon;
        word[LCLK_IE_BIT]  = csr.ie;
        return word;
    endfunction

endpackage

// File: rtl/wbc_edge_sync.sv
// -----------------------------------------------------------------------------
// wbc_edge_sync
// Rising-edge detector for the line-clock tick, with an optional 2-flop
// synchronizer in front of it (macro LCLK_SYNC_EN) for a tick that comes
// from a foreign clock domain.
//
// Ports:
//   clk   in  1  clock the detector runs on
//   rst   in  1  asynchronous, active-high reset
//   tick  in  1  raw tick square wave
//   rise  out 1  one-cycle pulse on each low->high transition of tick
//
// All history flops reset to 1 so that a tick already high when reset is
// released is not mistaken for a fresh edge.
// -----------------------------------------------------------------------------
module wbc_edge_sync
    import wbc_lclk_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic tick,
    output logic rise
);

    logic tick_s;   // tick as seen in the clk domain
    logic tick_d;   // tick_s one cycle ago

`ifdef LCLK_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], tick};
        end
    end

    assign tick_s = sync_q[1];
`else
    assign tick_s = tick;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its inputs regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_d <= 1'b1;
        end else begin
            tick_d <= tick_s;
        end
    end

    assign rise = tick_s & ~tick_d;

endmodule

// File: rtl/wbc_lclk.sv
// -----------------------------------------------------------------------------
// wbc_lclk
// KW11-L compatible line-clock peripheral on the system Wishbone bus.
// Consumes the 50 Hz square wave from the reset/timer block, keeps the CSR
// (monitor bit 7, interrupt enable bit 6) and raises a vectored interrupt
// that is retired by the CPU's acknowledge pulse.
//
// Build option: define LCLK_SYNC_EN to put a 2-flop synchronizer in front of
// the edge detector (tick from a foreign clock domain, 3-cycle latency).
//
// Parameters:
//   VECTOR            interrupt vector driven on ivec_o
//   TICK_DEFAULT_ENA  built-in tick gate; 0 makes the block ignore all ticks
//
// Ports:
//   wb_clk_i  in  1   system clock
//   wb_rst_i  in  1   asynchronous, active-high reset
//   wb_cyc_i  in  1   bus cycle
//   wb_stb_i  in  1   strobe (address decoded externally)
//   wb_we_i   in  1   write enable
//   wb_sel_i  in  2   byte selects (only the low byte holds CSR bits)
//   wb_dat_i  in  16  write data
//   wb_dat_o  out 16  registered read data, valid with wb_ack_o
//   wb_ack_o  out 1   one-cycle bus acknowledge
//   tick_i    in  1   timer square wave
//   tick_ena  in  1   front-panel timer enable; 0 = ticks ignored
//   irq_o     out 1   interrupt request
//   iack_i    in  1   interrupt acknowledge, one-cycle pulse
//   ivec_o    out 16  interrupt vector (constant VECTOR)
// -----------------------------------------------------------------------------
module wbc_lclk
    import wbc_lclk_pkg::*;
#(
    parameter logic [15:0] VECTOR           = LCLK_DEFAULT_VECTOR,
    parameter logic        TICK_DEFAULT_ENA = 1'b1
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [1:0]  wb_sel_i,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    output logic        wb_ack_o,
    input  logic        tick_i,
    input  logic        tick_ena,
    output logic        irq_o,
    input  logic        iack_i,
    output logic [15:0] ivec_o
);

    lclk_csr_t csr_q, csr_d;
    logic      pending_q, pending_d;
    logic      rise;
    logic      tick_gate;
    logic      tick_evt;
    logic      bus_req;
    logic      csr_wr;
    logic      unused_bits;

    // The KW11-L programming model has no bit that gates the tick, so the
    // enable flag is a build-time strap rather than a writable register.
    assign tick_gate = TICK_DEFAULT_ENA;

    wbc_edge_sync u_edge_sync (
        .clk  (wb_clk_i),
        .rst  (wb_rst_i),
        .tick (tick_i),
        .rise (rise)
    );

    assign tick_evt = rise & tick_ena & tick_gate;

    // A held strobe is accepted only on cycles where no ack is outstanding,
    // which yields one single-cycle ack per access.
    assign bus_req = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign csr_wr  = bus_req & wb_we_i & wb_sel_i[0];

    // Priority is expressed by statement order: later assignments win.
    //   mon:     tick event beats a mon-clear write, so a tick is never lost.
    //   pending: ie=0 write > (tick with ie as it was before the write) > iack.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        csr_d     = csr_q;
        pending_d = pending_q;

        if (csr_wr) begin
            csr_d.ie = wb_dat_i[LCLK_IE_BIT];
            if (!wb_dat_i[LCLK_MON_BIT]) begin
                csr_d.mon = 1'b0;
            end
        end
        if (tick_evt) begin
            csr_d.mon = 1'b1;
        end

        if (iack_i) begin
            pending_d = 1'b0;
        end
        // Setting ie while mon is already 1 deliberately does not request:
        // only a tick event can set pending.
        if (tick_evt && csr_q.ie) begin
            pending_d = 1'b1;
        end
        if (csr_wr && !wb_dat_i[LCLK_IE_BIT]) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            csr_q     <= '0;
            pending_q <= 1'b0;
            wb_ack_o  <= 1'b0;
            wb_dat_o  <= '0;
        end else begin
            csr_q     <= csr_d;
            pending_q <= pending_d;
            wb_ack_o  <= bus_req;
            if (bus_req) begin
                wb_dat_o <= lclk_csr_pack(csr_q);
            end
        end
    end

    assign irq_o  = pending_q;
    assign ivec_o = VECTOR;

    // Data bits outside the CSR and the high byte select carry no state.
    assign unused_bits = ^{wb_sel_i[1], wb_dat_i[15:8], wb_dat_i[5:0]};

endmodule

// File: tb/tb_wbc_lclk.sv
// -----------------------------------------------------------------------------
// tb_wbc_lclk
// Self-checking bench for wbc_lclk. A behavioural model of the line clock
// (mon/ie/request state driven by tick edges, writes and acknowledges) is
// compared with the DUT on every falling edge; directed scenarios add
// hand-computed literal expectations for CSR reads and timing.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wbc_lclk;

`ifdef LCLK_SYNC_EN
    localparam int SYNC_STAGES = 2;
`else
    localparam int SYNC_STAGES = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic        wb_we_i = 1'b0;
    logic [1:0]  wb_sel_i = 2'b00;
    logic [15:0] wb_dat_i = '0;
    logic [15:0] wb_dat_o;
    logic        wb_ack_o;
    logic        tick_i = 1'b0;
    logic        tick_ena = 1'b1;
    logic        irq_o;
    logic        iack_i = 1'b0;
    logic [15:0] ivec_o;

    int checks = 0;
    int errors = 0;

    wbc_lclk dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wb_cyc_i (wb_cyc_i),
        .wb_stb_i (wb_stb_i),
        .wb_we_i  (wb_we_i),
        .wb_sel_i (wb_sel_i),
        .wb_dat_i (wb_dat_i),
        .wb_dat_o (wb_dat_o),
        .wb_ack_o (wb_ack_o),
        .tick_i   (tick_i),
        .tick_ena (tick_ena),
        .irq_o    (irq_o),
        .iack_i   (iack_i),
        .ivec_o   (ivec_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        m_mon, m_ie, m_req, m_ack, m_prev;
    logic [15:0] m_dat;
    logic [1:0]  m_hist;

    always @(posedge clk or posedge rst) begin
        logic t, ev, access, wr;
        if (rst) begin
            m_mon = 0; m_ie = 0; m_req = 0; m_ack = 0; m_prev = 1;
            m_dat = 0; m_hist = 2'b11;
        end else begin
`ifdef LCLK_SYNC_EN
            t      = m_hist[1];
            m_hist = {m_hist[0], tick_i};
`else
            t      = tick_i;
`endif
            ev     = t && !m_prev && tick_ena;
            m_prev = t;
            access = wb_cyc_i && wb_stb_i && !m_ack;
            wr     = access && wb_we_i && wb_sel_i[0];
            if (access) m_dat = {8'h00, m_mon, m_ie, 6'b0};
            // Request: ie=0 write cancels; else tick with old ie requests;
            // else acknowledge retires.
            if (wr && !wb_dat_i[6])  m_req = 0;
            else if (ev && m_ie)     m_req = 1;
            else if (iack_i)         m_req = 0;
            if (ev)                  m_mon = 1;
            else if (wr && !wb_dat_i[7]) m_mon = 0;
            if (wr)                  m_ie = wb_dat_i[6];
            m_ack = access;
        end
    end

    always @(negedge clk) begin
        check("irq_o_model", 32'(irq_o), 32'(m_req));
        check("ack_model", 32'(wb_ack_o), 32'(m_ack));
        check("dat_model", 32'(wb_dat_o), 32'(m_dat));
    end

    // ---------------- stimulus helpers ----------------
    task automatic bus_access(input logic we, input logic [1:0] sel, input logic [15:0] dat,
                              input bit aligned, output logic [15:0] rdata, output int lat);
        if (!aligned) begin
            @(negedge clk); #1;
        end
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = we; wb_sel_i = sel; wb_dat_i = dat;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!wb_ack_o && lat < 10);
        rdata = wb_dat_o;
        #1;
        wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_sel_i = 0; wb_dat_i = 0;
    endtask

    task automatic csr_read(input string name, input logic [15:0] exp);
        logic [15:0] d;
        int lat;
        bus_access(1'b0, 2'b11, 16'h0, 1'b0, d, lat);
        check({name, "_lat"}, 32'(lat), 32'd1);
        check(name, 32'(d), 32'(exp));
    endtask

    task automatic csr_write(input string name, input logic [1:0] sel, input logic [15:0] dat,
                             input bit aligned);
        logic [15:0] d;
        int lat;
        bus_access(1'b1, sel, dat, aligned, d, lat);
        check({name, "_lat"}, 32'(lat), 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Raise tick and return at the point where a same-cycle action lands on
    // the edge that detects it.
    task automatic tick_rise_aligned();
        @(negedge clk); #1;
        tick_i = 1;
        for (int i = 0; i < SYNC_STAGES; i++) begin
            @(negedge clk); #1;
        end
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int n;
        idle(3);
        check("reset_irq", 32'(irq_o), 32'd0);
        check("reset_ack", 32'(wb_ack_o), 32'd0);
        check("reset_dat", 32'(wb_dat_o), 32'd0);
        check("ivec", 32'(ivec_o), 32'(16'o000100));
        rst = 0;
        idle(2);

        csr_read("rd_after_reset", 16'o000000);

        // Tick with ie=0: monitor only.
        @(negedge clk); #1 tick_i = 1;
        idle(3);
        tick_i = 0;
        idle(SYNC_STAGES + 2);
        check("no_irq_ie0", 32'(irq_o), 32'd0);
        csr_read("rd_mon_only", 16'o000200);

        // Enable interrupts (clears mon), then tick.
        csr_write("wr_ie", 2'b11, 16'o000100, 1'b0);
        csr_read("rd_ie_only", 16'o000100);
        @(negedge clk); #1 tick_i = 1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!irq_o && n < 10);
        check("irq_latency", 32'(n), 32'(1 + SYNC_STAGES));
        #1 iack_i = 1;
        @(negedge clk);
        check("irq_after_iack", 32'(irq_o), 32'd0);
        #1 iack_i = 0;
        csr_read("rd_after_iack", 16'o000300);
        tick_i = 0;
        idle(SYNC_STAGES + 2);

        // Setting ie while mon=1 raises nothing.
        csr_write("wr_ie_mon1", 2'b11, 16'o000300, 1'b0);
        idle(4);
        check("no_irq_ie_set", 32'(irq_o), 32'd0);
        csr_read("rd_ie_mon1", 16'o000300);

        // Mon-clear write on the same edge as a tick: tick wins.
        csr_write("wr_clr_mon", 2'b11, 16'o000100, 1'b0);
        tick_rise_aligned();
        csr_write("wr_coincident", 2'b11, 16'o000100, 1'b1);
        idle(1);
        check("irq_coincident", 32'(irq_o), 32'd1);
        csr_read("rd_coincident", 16'o000300);

        // Reset mid-operation with tick held high across release.
        @(negedge clk); #1 rst = 1;
        #1;
        check("async_rst_irq", 32'(irq_o), 32'd0);
        check("async_rst_ack", 32'(wb_ack_o), 32'd0);
        idle(3);
        rst = 0;
        idle(1000);
        check("held_tick_irq", 32'(irq_o), 32'd0);
        csr_read("rd_held_tick", 16'o000000);
        tick_i = 0;
        idle(SYNC_STAGES + 2);
        tick_i = 1;
        idle(SYNC_STAGES + 2);
        csr_read("rd_next_rise", 16'o000200);
        tick_i = 0;
        idle(SYNC_STAGES + 2);

        // Ticks ignored while disabled; high-byte-only write ignored but acked.
        csr_write("wr_ie2", 2'b11, 16'o000100, 1'b0);
        tick_ena = 0;
        for (int i = 0; i < 5; i++) begin
            tick_i = 1; idle(2);
            tick_i = 0; idle(3);
        end
        idle(SYNC_STAGES + 2);
        check("no_irq_disabled", 32'(irq_o), 32'd0);
        csr_read("rd_disabled", 16'o000100);
        csr_write("wr_sel_hi", 2'b10, 16'o000000, 1'b0);
        csr_read("rd_sel_hi", 16'o000100);
        tick_ena = 1;

        // Tick and iack on the same edge: request survives.
        @(negedge clk); #1 tick_i = 1;
        idle(SYNC_STAGES + 2);
        check("irq_pre_iack", 32'(irq_o), 32'd1);
        tick_i = 0;
        idle(SYNC_STAGES + 2);
        tick_rise_aligned();
        iack_i = 1;
        @(negedge clk);
        check("irq_tick_iack", 32'(irq_o), 32'd1);
        #1 iack_i = 0;
        @(negedge clk); #1 iack_i = 1;
        @(negedge clk);
        check("irq_iack_clear", 32'(irq_o), 32'd0);
        #1 iack_i = 0;
        tick_i = 0;

        // Held strobe: ack every second cycle.
        @(negedge clk); #1;
        wb_cyc_i = 1; wb_stb_i = 1; wb_we_i = 0;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (wb_ack_o) n++;
        end
        #1 wb_cyc_i = 0; wb_stb_i = 0;
        check("held_stb_acks", 32'(n), 32'd3);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
